// File: rtl/risc_pkg.sv
// Shared definitions for the RISC packet fetch stage: opcodes, header layout, FSM states.
// Header word: [31:28] opcode, [27] Asel, [26:16] reserved, [15:0] add.
package risc_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ISSUE = 4'h1;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int HDR_OP_MSB   = 31;
    localparam int HDR_OP_LSB   = 28;
    localparam int HDR_ASEL_BIT = 27;
    localparam int HDR_ADD_MSB  = 15;
    localparam int HDR_ADD_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_OPA   = 3'd2,
        ST_OPB   = 3'd3,
        ST_ISSUE = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_ISSUE) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/risc_packet_fetch_if.sv
// Program-memory read port plus the valid/ready operand bus toward the RISC core.
// master = fetch stage, slave = memory/core side.
interface risc_packet_fetch_if #(
    parameter int PC_W = 8
);
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     A;
    logic [31:0]     B;
    logic            Asel;
    logic [15:0]     add;

    modport master (
        output imem_en, imem_addr, out_valid, A, B, Asel, add,
        input  imem_data, out_ready
    );

    modport slave (
        input  imem_en, imem_addr, out_valid, A, B, Asel, add,
        output imem_data, out_ready
    );
endinterface

// File: rtl/risc_packet_fetch.sv
// Unpacks {header, A, B} packets from program memory into RISC operands; start to out_valid = 4 cycles,
// one packet per 4 cycles with ready high; holds the operand set stable while out_ready is low.
module risc_packet_fetch
    import risc_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    risc_packet_fetch_if.master bus,
    output logic                busy,
    output logic                halted,
    output logic                err
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic            r_asel;
    logic [15:0]     r_add;
    logic            r_valid;
    logic            r_halted;
    logic            r_err;

    logic [3:0]      w_op;
    logic            w_hs;
    logic            w_fetch;

    assign w_op = bus.imem_data[HDR_OP_MSB:HDR_OP_LSB];
    assign w_hs = r_valid && bus.out_ready;

    // Memory returns data the cycle after the request, so the request is issued in the
    // cycle before the word is consumed; r_pc therefore always names the next word to fetch.
    always_comb begin
        w_fetch = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: w_fetch = start;
            ST_HDR:           w_fetch = (w_op != OP_HALT);
            ST_OPA:           w_fetch = 1'b1;
            ST_ISSUE:         w_fetch = w_hs;
            default:          w_fetch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= START_PC;
            r_a      <= '0;
            r_b      <= '0;
            r_asel   <= 1'b0;
            r_add    <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_pc <= r_pc + 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_halted <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!op_is_legal(w_op)) begin
                        r_err <= 1'b1;
                    end
                    case (w_op)
                        OP_ISSUE: begin
                            r_asel  <= bus.imem_data[HDR_ASEL_BIT];
                            r_add   <= bus.imem_data[HDR_ADD_MSB:HDR_ADD_LSB];
                            r_state <= ST_OPA;
                        end
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end
                        default: r_state <= ST_HDR;
                    endcase
                end
                ST_OPA: begin
                    r_a     <= bus.imem_data;
                    r_state <= ST_OPB;
                end
                ST_OPB: begin
                    r_b     <= bus.imem_data;
                    r_valid <= 1'b1;
                    r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_state <= ST_HDR;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.imem_en   = w_fetch;
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = r_valid;
    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.Asel      = r_asel;
    assign bus.add       = r_add;
    assign busy          = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign halted        = r_halted;
    assign err           = r_err;

endmodule

// File: tb/tb_risc_packet_fetch.sv
// Bench for risc_packet_fetch: one-packet vector table, hand-written corner sequences,
// and random programs checked against a word-walking reference model.
module tb_risc_packet_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, start1;
    logic busy0, halted0, err0;
    logic busy1, halted1, err1;

    risc_packet_fetch_if #(.PC_W(8)) bus0();
    risc_packet_fetch_if #(.PC_W(4)) bus1();

    risc_packet_fetch #(.PC_W(8), .START_PC(8'd0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .bus(bus0),
        .busy(busy0), .halted(halted0), .err(err0)
    );

    risc_packet_fetch #(.PC_W(4), .START_PC(4'd14)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .bus(bus1),
        .busy(busy1), .halted(halted1), .err(err1)
    );

    localparam logic [31:0] HALT_W = 32'hF000_0000;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [16];
    logic [31:0] rd0, rd1;

    always @(posedge clk) begin
        if (bus0.imem_en) rd0 <= mem0[bus0.imem_addr];
        if (bus1.imem_en) rd1 <= mem1[bus1.imem_addr];
    end
    assign bus0.imem_data = rd0;
    assign bus1.imem_data = rd1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        asel;
        logic [15:0] add;
    } pkt_t;

    typedef struct {
        logic [31:0] pre;
        logic [31:0] hdr;
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic        exp_asel;
        logic [15:0] exp_add;
        int          exp_cyc;
        logic        exp_err;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   gcyc  = 0;
    int   t0    = 0;
    pkt_t hs_q[$];
    int   hs_cyc[$];
    pkt_t hs1_q[$];
    int   f1_q[$];
    pkt_t exp_q[$];

    always @(posedge clk) gcyc <= gcyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus0.out_valid && bus0.out_ready) begin
                hs_q.push_back({bus0.A, bus0.B, bus0.Asel, bus0.add});
                hs_cyc.push_back(gcyc - t0);
            end
            if (bus1.out_valid && bus1.out_ready)
                hs1_q.push_back({bus1.A, bus1.B, bus1.Asel, bus1.add});
            if (bus1.imem_en)
                f1_q.push_back(int'(bus1.imem_addr));
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill0();
        for (int k = 0; k < 256; k++) mem0[k] = HALT_W;
    endtask

    task automatic do_reset();
        start0 = 1'b0;
        start1 = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", bus0.out_valid, 0);
        chk("rst_ab", {bus0.A, bus0.B}, 0);
        chk("rst_hdr", {bus0.Asel, bus0.add}, 0);
        chk("rst_flags", {halted0, err0, busy0, bus0.imem_en}, 0);
        chk("rst_pc0", bus0.imem_addr, 0);
        chk("rst_pc1", bus1.imem_addr, 14);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        hs_q.delete();
        hs_cyc.delete();
        hs1_q.delete();
        f1_q.delete();
    endtask

    task automatic start_dut0(input logic rdy);
        tick();
        t0 = gcyc;
        start0 = 1'b1;
        bus0.out_ready = rdy;
        tick();
        start0 = 1'b0;
    endtask

    task automatic run_to_halt0(input int budget, input bit rnd);
        int n = 0;
        while (!halted0 && n < budget) begin
            if (rnd) bus0.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("halt_reached", halted0, 1);
    endtask

    // Reference: walk the program word by word from start_pc until a HALT header.
    task automatic model_run(input int start_pc, output int end_pc, output bit e);
        int pc;
        logic [31:0] w;
        exp_q.delete();
        e  = 1'b0;
        pc = start_pc;
        for (int guard = 0; guard < 256; guard++) begin
            w = mem0[pc];
            if (w[31:28] == 4'h1) begin
                exp_q.push_back({mem0[(pc + 1) % 256], mem0[(pc + 2) % 256], w[27], w[15:0]});
                pc = (pc + 3) % 256;
            end else if (w[31:28] == 4'hF) begin
                pc = (pc + 1) % 256;
                break;
            end else begin
                if (w[31:28] != 4'h0) e = 1'b1;
                pc = (pc + 1) % 256;
            end
        end
        end_pc = pc;
    endtask

    vec_t        vt [5];
    logic [31:0] a_tab [4];

    initial begin
        int   vcnt;
        int   n;
        int   end_pc;
        bit   e_exp;
        int   p;
        int   r;
        int   bad_cnt;
        logic [31:0] rw;
        pkt_t ep;

        rst = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;

        //        pre            hdr            A              B          stall asel add       cyc err
        vt[0] = '{32'h0000_0000, 32'h1000_0003, 32'd12,        32'd14,        0, 1'b0, 16'h0003, 5, 1'b0};
        vt[1] = '{32'h7000_0000, 32'h1800_BEEF, 32'hDEAD_BEEF, 32'h0,         0, 1'b1, 16'hBEEF, 5, 1'b1};
        vt[2] = '{32'h0FFF_FFFF, 32'h17FF_1234, 32'hFFFF_FFFF, 32'h1,         5, 1'b0, 16'h1234, 10, 1'b0};
        vt[3] = '{32'h2000_0000, 32'h1FFF_FFFF, 32'h0,         32'h8000_0000, 2, 1'b1, 16'hFFFF, 7, 1'b1};
        vt[4] = '{32'hE000_0001, 32'h1000_0000, 32'd5,         32'd6,         1, 1'b0, 16'h0000, 6, 1'b1};
        a_tab = '{32'd12, 32'd10, 32'd15, 32'd17};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            fill0();
            mem0[0] = vt[i].pre;
            mem0[1] = vt[i].hdr;
            mem0[2] = vt[i].a;
            mem0[3] = vt[i].b;
            start_dut0(vt[i].stall == 0);
            vcnt = 0;
            n = 0;
            while (!halted0 && n < 60) begin
                if (bus0.out_valid) begin
                    vcnt++;
                    chk("vec_hold", {bus0.A, bus0.B, bus0.add}, {vt[i].a, vt[i].b, vt[i].exp_add});
                    bus0.out_ready = (vcnt > vt[i].stall);
                end
                tick();
                n++;
            end
            chk("vec_halted", halted0, 1);
            chk("vec_valid_cycles", vcnt, vt[i].stall + 1);
            chk("vec_hs_count", hs_q.size(), 1);
            if (hs_q.size() > 0) begin
                ep = {vt[i].a, vt[i].b, vt[i].exp_asel, vt[i].exp_add};
                chk("vec_pkt", hs_q[0], ep);
                chk("vec_hs_cycle", hs_cyc[0], vt[i].exp_cyc);
            end
            chk("vec_err", err0, vt[i].exp_err);
            chk("vec_idle_flags", {busy0, bus0.out_valid}, 0);
            chk("vec_retain_a", bus0.A, vt[i].a);
            chk("vec_end_pc", bus0.imem_addr, 5);
        end

        // Four back-to-back packets, start pulse mid-stream must be ignored.
        do_reset();
        fill0();
        for (int j = 0; j < 4; j++) begin
            mem0[3 * j]     = 32'h1000_0003 + 32'(j);
            mem0[3 * j + 1] = a_tab[j];
            mem0[3 * j + 2] = 32'd14;
        end
        start_dut0(1'b1);
        for (int k = 1; k < 24 && !halted0; k++) begin
            if (k == 3) chk("lat_c3_valid", bus0.out_valid, 0);
            if (k == 4) begin
                chk("lat_c4_valid", bus0.out_valid, 1);
                chk("lat_c4_addr", {bus0.imem_en, bus0.imem_addr}, {1'b1, 8'd3});
            end
            start0 = (k == 6);
            tick();
        end
        start0 = 1'b0;
        chk("b2b_halted", halted0, 1);
        chk("b2b_count", hs_q.size(), 4);
        for (int j = 0; j < 4 && j < hs_q.size(); j++) begin
            ep = {a_tab[j], 32'd14, 1'b0, 16'(3 + j)};
            chk("b2b_pkt", hs_q[j], ep);
            chk("b2b_cycle", hs_cyc[j], 4 * (j + 1));
        end

        // NOP, illegal, ISSUE, HALT; then restart from HALT.
        do_reset();
        fill0();
        mem0[0] = 32'h0000_0000;
        mem0[1] = 32'h7000_0000;
        mem0[2] = 32'h1000_0042;
        mem0[3] = 32'h11;
        mem0[4] = 32'h22;
        start_dut0(1'b1);
        run_to_halt0(40, 1'b0);
        chk("mix_err", err0, 1);
        chk("mix_count", hs_q.size(), 1);
        chk("mix_busy", busy0, 0);
        chk("mix_pc", bus0.imem_addr, 6);
        start_dut0(1'b1);
        chk("restart_flags", {halted0, err0, busy0}, 3'b001);
        run_to_halt0(20, 1'b0);
        chk("restart_pc", bus0.imem_addr, 7);
        chk("restart_state", {err0, hs_q.size() == 1, bus0.A}, {1'b0, 1'b1, 32'h11});

        // Asynchronous reset while in OPB.
        do_reset();
        fill0();
        mem0[0] = 32'h1000_0077;
        mem0[1] = 32'h1;
        mem0[2] = 32'h2;
        start_dut0(1'b1);
        tick();
        tick();
        chk("pre_abort", {bus0.A, bus0.add, bus0.imem_addr}, {32'h1, 16'h77, 8'd3});
        #3;
        rst = 1'b0;
        #1;
        chk("abort_regs", {bus0.A, bus0.B, bus0.Asel, bus0.add}, 0);
        chk("abort_flags", {bus0.out_valid, busy0, halted0, bus0.imem_addr}, 0);
        @(negedge clk);
        rst = 1'b1;
        bad_cnt = 0;
        bus0.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus0.out_valid || bus0.imem_en || busy0) bad_cnt++;
        end
        chk("abort_quiet", bad_cnt, 0);
        chk("abort_no_hs", hs_q.size(), 0);

        // Packet straddling the 4-bit PC wrap.
        do_reset();
        for (int k = 0; k < 16; k++) mem1[k] = HALT_W;
        mem1[14] = 32'h1000_00AA;
        mem1[15] = 32'h0000_1111;
        mem1[0]  = 32'h0000_2222;
        tick();
        start1 = 1'b1;
        bus1.out_ready = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!halted1 && n < 30) begin
            if (bus1.out_valid) chk("wrap_hs_addr", bus1.imem_addr, 1);
            tick();
            n++;
        end
        chk("wrap_halted", halted1, 1);
        chk("wrap_fetch_n", f1_q.size(), 4);
        if (f1_q.size() >= 3) chk("wrap_fetch", {f1_q[0], f1_q[1], f1_q[2]}, {32'd14, 32'd15, 32'd0});
        chk("wrap_hs_count", hs1_q.size(), 1);
        if (hs1_q.size() > 0) begin
            ep = {32'h1111, 32'h2222, 1'b0, 16'h00AA};
            chk("wrap_pkt", hs1_q[0], ep);
        end
        chk("wrap_end_pc", bus1.imem_addr, 2);

        // Random programs with random ready against the reference model.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            fill0();
            p = 0;
            while (p < 40) begin
                r  = $urandom_range(0, 9);
                rw = $urandom;
                if (r < 5) begin
                    mem0[p]     = {4'h1, rw[27:0]};
                    mem0[p + 1] = $urandom;
                    mem0[p + 2] = $urandom;
                    p += 3;
                end else if (r < 8) begin
                    mem0[p] = {4'h0, rw[27:0]};
                    p += 1;
                end else begin
                    mem0[p] = {4'($urandom_range(2, 14)), rw[27:0]};
                    p += 1;
                end
            end
            rw = $urandom;
            mem0[p] = {4'hF, rw[27:0]};
            model_run(0, end_pc, e_exp);
            start_dut0(1'b0);
            run_to_halt0(800, 1'b1);
            chk("rnd_count", hs_q.size(), exp_q.size());
            for (int j = 0; j < hs_q.size() && j < exp_q.size(); j++)
                chk("rnd_pkt", hs_q[j], exp_q[j]);
            chk("rnd_err", err0, e_exp);
            chk("rnd_end_pc", bus0.imem_addr, end_pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
